// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit common-anode seven-segment scan controller
// with anti-ghost blanking and a two-port round-robin digit write arbiter.
module seg_scan_ctrl #(
   parameter int TICK_DIV  = 100000,
   parameter int BLANK_CYC = 100
) (
   input  logic       mclk94,
   input  logic       rstn94,
   input  logic       en94,
   input  logic [7:0] bmask94,
   input  logic       req_a94,
   input  logic [2:0] dig_a94,
   input  logic [3:0] val_a94,
   input  logic       req_b94,
   input  logic [2:0] dig_b94,
   input  logic [3:0] val_b94,
   output logic       ack_a94,
   output logic       ack_b94,
   output logic [7:0] an94,
   output logic [6:0] ssg94,
   output logic [2:0] idx94
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PBLK = PW'(BLANK_CYC);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } phase_t;

   function automatic logic [6:0] seg_dec(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b1011000;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         4'hF: s = 7'b1110001;
      endcase
      return s;
   endfunction

   logic [1:0]    rsync;
   logic          rst_n;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_nx;
   logic [2:0]    idx;
   logic [2:0]    idx_nx;
   logic          wrap;
   phase_t        phase;
   phase_t        phase_nx;
   logic [3:0]    vfile [8];
   logic          rr;
   logic          el_a;
   logic          el_b;
   logic          gnt_a;
   logic          gnt_b;
   logic [2:0]    wr_dig;
   logic [3:0]    wr_val;
   logic [7:0]    an_nx;
   logic [6:0]    ssg_nx;

   // assert immediately, release two edges after rstn94 rises
   always_ff @(posedge mclk94 or negedge rstn94) begin
      if (!rstn94) rsync <= 2'b00;
      else         rsync <= {rsync[0], 1'b1};
   end

   assign rst_n = rsync[1];
   assign idx94 = idx;

   always_comb begin
      wrap    = (pcnt == PMAX);
      pcnt_nx = pcnt;
      idx_nx  = idx;
      if (en94) begin
         if (wrap) begin
            pcnt_nx = '0;
            idx_nx  = idx + 3'd1;
         end else begin
            pcnt_nx = pcnt + PW'(1);
         end
      end
   end

   always_ff @(posedge mclk94 or negedge rst_n) begin
      if (!rst_n) begin
         pcnt  <= '0;
         idx   <= 3'd0;
         phase <= BLANK;
      end else begin
         pcnt  <= pcnt_nx;
         idx   <= idx_nx;
         phase <= phase_nx;
      end
   end

   always_comb begin
      phase_nx = phase;
      if (en94) begin
         unique case (phase)
            BLANK: if (pcnt_nx == PBLK) phase_nx = SHOW;
            SHOW:  if (wrap)            phase_nx = BLANK;
         endcase
      end
   end

   // outputs are computed from the post-edge scan state
   always_comb begin
      an_nx  = 8'hFF;
      ssg_nx = 7'h7F;
      if (en94 && phase_nx == SHOW && !bmask94[idx_nx]) begin
         an_nx  = ~(8'd1 << idx_nx);
         ssg_nx = ~seg_dec(vfile[idx_nx]);
      end
   end

   // a requester is deaf during its own ack cycle
   always_comb begin
      el_a   = req_a94 & ~ack_a94;
      el_b   = req_b94 & ~ack_b94;
      gnt_a  = el_a & (~el_b | ~rr);
      gnt_b  = el_b & (~el_a | rr);
      wr_dig = gnt_a ? dig_a94 : dig_b94;
      wr_val = gnt_a ? val_a94 : val_b94;
   end

   always_ff @(posedge mclk94 or negedge rst_n) begin
      if (!rst_n) begin
         an94    <= 8'hFF;
         ssg94   <= 7'h7F;
         ack_a94 <= 1'b0;
         ack_b94 <= 1'b0;
      end else begin
         an94    <= an_nx;
         ssg94   <= ssg_nx;
         ack_a94 <= gnt_a;
         ack_b94 <= gnt_b;
      end
   end

   always_ff @(posedge mclk94 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) vfile[i] <= 4'h0;
      end else if (gnt_a | gnt_b) begin
         vfile[wr_dig] <= wr_val;
      end
   end

   always_ff @(posedge mclk94 or negedge rst_n) begin
      if (!rst_n)     rr <= 1'b0;
      else if (gnt_a) rr <= 1'b1;
      else if (gnt_b) rr <= 1'b0;
   end

endmodule
